// File: rtl/mips_wdt_pkg.sv
// mips_wdt_pkg: shared watchdog state encoding and default parameter constants
package mips_wdt_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    S_DISABLED = 2'd0,
    S_RUN      = 2'd1,
    S_BITE     = 2'd2
  } wdt_state_e;
  localparam int DEF_CNT_WIDTH    = 32;
  localparam int DEF_PERIOD       = 1000;
  localparam int DEF_WARN_MARGIN  = 16;
  localparam int DEF_PULSE_CYCLES = 4;
  localparam int DEF_TO_CNT_WIDTH = 8;
endpackage

// File: rtl/mips_wdt_down_counter.sv
// mips_wdt_down_counter: loadable down-counter saturating at zero (ports: i_clk, i_reset, i_load, i_value, i_en, o_count, o_zero)
module mips_wdt_down_counter #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_zero
);
  logic [W-1:0] r_count;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_count <= RST_VAL;
    else if (i_load) r_count <= i_value;
    else if (i_en && r_count != '0) r_count <= r_count - W'(1);
  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
endmodule

// File: rtl/mips_wdt_controller.sv
// mips_wdt_controller: watchdog FSM driving a fixed-length CPU reset pulse (ports: i_clk, i_reset, i_enable, i_kick, i_period_w_en, i_period_data, o_cpu_reset, o_warning, o_timeout_count, o_state)
module mips_wdt_controller
  import mips_wdt_pkg::*;
#(
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int DEFAULT_PERIOD = DEF_PERIOD,
  parameter int WARN_MARGIN    = DEF_WARN_MARGIN,
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int TO_CNT_WIDTH   = DEF_TO_CNT_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_kick,
  input  logic                    i_period_w_en,
  input  logic [CNT_WIDTH-1:0]    i_period_data,
  output logic                    o_cpu_reset,
  output logic                    o_warning,
  output logic [TO_CNT_WIDTH-1:0] o_timeout_count,
  output logic [STATE_W-1:0]      o_state
);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  wdt_state_e              r_state;
  logic [CNT_WIDTH-1:0]    r_period;
  logic                    r_cpu_reset;
  logic [TO_CNT_WIDTH-1:0] r_to_cnt;
  logic                    w_wr, w_run_go, w_bite;
  logic                    w_cnt_load, w_cnt_zero, w_pulse_zero;
  logic [CNT_WIDTH-1:0]    w_cnt_val, w_cnt;
  logic [PW-1:0]           w_pulse_cnt;
  logic                    w_unused;
  assign w_wr = i_period_w_en && (i_period_data != '0);
  // Plain counting in RUN: no disable, no reload from a kick or a period write.
  assign w_run_go = (r_state == S_RUN) && i_enable && !w_wr && !i_kick;
  assign w_bite = w_run_go && w_cnt_zero;
  // Outside counting the main count tracks the period, except while a pulse is still running.
  assign w_cnt_load = !w_run_go && !((r_state == S_BITE) && !w_pulse_zero);
  assign w_cnt_val = ((r_state == S_RUN) && i_enable && w_wr) ? i_period_data : r_period;
  assign w_unused = ^w_pulse_cnt;
  mips_wdt_down_counter #(.W(CNT_WIDTH), .RST_VAL(CNT_WIDTH'(DEFAULT_PERIOD))) u_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_cnt_load),
    .i_value (w_cnt_val),
    .i_en    (w_run_go),
    .o_count (w_cnt),
    .o_zero  (w_cnt_zero)
  );
  mips_wdt_down_counter #(.W(PW), .RST_VAL('0)) u_pulse (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_bite),
    .i_value (PW'(PULSE_CYCLES - 1)),
    .i_en    (r_state == S_BITE),
    .o_count (w_pulse_cnt),
    .o_zero  (w_pulse_zero)
  );
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_DISABLED;
      r_period    <= CNT_WIDTH'(DEFAULT_PERIOD);
      r_cpu_reset <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      if (w_wr) r_period <= i_period_data;
      case (r_state)
        S_DISABLED: if (i_enable) r_state <= S_RUN;
        S_RUN: begin
          if (!i_enable) r_state <= S_DISABLED;
          else if (w_bite) begin
            r_state     <= S_BITE;
            r_cpu_reset <= 1'b1;
          end
        end
        S_BITE: begin
          if (w_pulse_zero) begin
            r_cpu_reset <= 1'b0;
            r_to_cnt    <= (&r_to_cnt) ? r_to_cnt : r_to_cnt + TO_CNT_WIDTH'(1);
            r_state     <= i_enable ? S_RUN : S_DISABLED;
          end
        end
        default: begin
          r_state     <= S_DISABLED;
          r_cpu_reset <= 1'b0;
        end
      endcase
    end
  end
  assign o_cpu_reset     = r_cpu_reset;
  assign o_warning       = (r_state == S_RUN) && (w_cnt <= CNT_WIDTH'(WARN_MARGIN));
  assign o_timeout_count = r_to_cnt;
  assign o_state         = r_state;
endmodule

// File: tb/tb_mips_wdt_controller.sv
// tb_mips_wdt_controller: directed self-checking bench for the watchdog controller
module tb_mips_wdt_controller;
  localparam int CW = 16;
  logic          clk = 1'b0;
  logic          rst, en, kick, pw_en;
  logic [CW-1:0] pdata;
  logic          cpu_rst, warn;
  logic [7:0]    to_cnt;
  logic [1:0]    st;
  int errors = 0;
  int checks = 0;

  mips_wdt_controller #(
    .CNT_WIDTH(CW), .DEFAULT_PERIOD(10), .WARN_MARGIN(3), .PULSE_CYCLES(4), .TO_CNT_WIDTH(8)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_kick(kick),
    .i_period_w_en(pw_en), .i_period_data(pdata),
    .o_cpu_reset(cpu_rst), .o_warning(warn), .o_timeout_count(to_cnt), .o_state(st)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; kick = 1'b0; pw_en = 1'b0; pdata = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL reset_cpu_rst: got %0b want 0", cpu_rst); end
    checks++; if (warn !== 1'b0) begin errors++; $display("FAIL reset_warn: got %0b want 0", warn); end
    checks++; if (to_cnt !== 8'd0) begin errors++; $display("FAIL reset_to_cnt: got %0d want 0", to_cnt); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st); end
    checks++; if (dut.w_cnt !== 16'd10) begin errors++; $display("FAIL reset_cnt: got %0d want 10", dut.w_cnt); end
    checks++; if (dut.r_period !== 16'd10) begin errors++; $display("FAIL reset_period: got %0d want 10", dut.r_period); end
  endtask

  task automatic test_bite();
    do_reset();
    en = 1'b1;
    step();
    checks++; if (st !== 2'd1 || dut.w_cnt !== 16'd10) begin errors++; $display("FAIL bite_start: state %0d cnt %0d want 1/10", st, dut.w_cnt); end
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (dut.w_cnt !== 16'(10 - k)) begin errors++; $display("FAIL bite_cnt: got %0d want %0d", dut.w_cnt, 10 - k); end
      checks++; if (warn !== ((10 - k) <= 3)) begin errors++; $display("FAIL bite_warn: cnt %0d got %0b want %0b", 10 - k, warn, (10 - k) <= 3); end
      checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL bite_early: got %0b want 0", cpu_rst); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (cpu_rst !== 1'b1 || st !== 2'd2) begin errors++; $display("FAIL bite_pulse%0d: rst %0b state %0d want 1/2", i, cpu_rst, st); end
    end
    step();
    checks++; if (cpu_rst !== 1'b0) begin errors++; $display("FAIL bite_end: got %0b want 0", cpu_rst); end
    checks++; if (to_cnt !== 8'd1) begin errors++; $display("FAIL bite_to_cnt: got %0d want 1", to_cnt); end
    checks++; if (st !== 2'd1 || dut.w_cnt !== 16'd10) begin errors++; $display("FAIL bite_rerun: state %0d cnt %0d want 1/10", st, dut.w_cnt); end
  endtask

  task automatic test_kick_periodic();
    logic seen = 1'b0;
    do_reset();
    en = 1'b1;
    step();
    for (int i = 0; i < 200; i++) begin
      kick = (i % 8 == 7);
      step();
      if (cpu_rst) seen = 1'b1;
    end
    kick = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL kick_no_bite: got %0b want 0", seen); end
    checks++; if (to_cnt !== 8'd0) begin errors++; $display("FAIL kick_to_cnt: got %0d want 0", to_cnt); end
  endtask

  task automatic test_kick_at_zero();
    do_reset();
    en = 1'b1;
    step();
    repeat (10) step();
    checks++; if (dut.w_cnt !== 16'd0) begin errors++; $display("FAIL kz_cnt0: got %0d want 0", dut.w_cnt); end
    kick = 1'b1;
    step();
    kick = 1'b0;
    checks++; if (dut.w_cnt !== 16'd10 || st !== 2'd1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL kz_kick: cnt %0d state %0d rst %0b want 10/1/0", dut.w_cnt, st, cpu_rst); end
    repeat (10) step();
    pw_en = 1'b1; pdata = 16'd20;
    step();
    pw_en = 1'b0;
    checks++; if (dut.w_cnt !== 16'd20 || st !== 2'd1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL kz_write: cnt %0d state %0d rst %0b want 20/1/0", dut.w_cnt, st, cpu_rst); end
    checks++; if (dut.r_period !== 16'd20) begin errors++; $display("FAIL kz_period: got %0d want 20", dut.r_period); end
  endtask

  task automatic test_zero_write_bite_toggles();
    do_reset();
    en = 1'b1;
    step();
    repeat (2) step();
    pw_en = 1'b1; pdata = 16'd0;
    step();
    pw_en = 1'b0;
    checks++; if (dut.w_cnt !== 16'd7 || dut.r_period !== 16'd10) begin errors++; $display("FAIL zw: cnt %0d period %0d want 7/10", dut.w_cnt, dut.r_period); end
    repeat (8) step();
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL tg_p0: got %0b want 1", cpu_rst); end
    kick = 1'b1; en = 1'b0; pw_en = 1'b1; pdata = 16'd5;
    step();
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL tg_p1: got %0b want 1", cpu_rst); end
    kick = 1'b0; en = 1'b1; pw_en = 1'b0;
    step();
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL tg_p2: got %0b want 1", cpu_rst); end
    en = 1'b0;
    step();
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL tg_p3: got %0b want 1", cpu_rst); end
    en = 1'b1; kick = 1'b1;
    step();
    kick = 1'b0;
    checks++; if (cpu_rst !== 1'b0 || to_cnt !== 8'd1) begin errors++; $display("FAIL tg_end: rst %0b to %0d want 0/1", cpu_rst, to_cnt); end
    checks++; if (st !== 2'd1 || dut.w_cnt !== 16'd5 || dut.r_period !== 16'd5) begin errors++; $display("FAIL tg_rerun: state %0d cnt %0d period %0d want 1/5/5", st, dut.w_cnt, dut.r_period); end
  endtask

  task automatic test_disable();
    logic seen = 1'b0;
    do_reset();
    en = 1'b1;
    step();
    repeat (5) step();
    checks++; if (dut.w_cnt !== 16'd5) begin errors++; $display("FAIL dis_cnt5: got %0d want 5", dut.w_cnt); end
    en = 1'b0;
    step();
    checks++; if (st !== 2'd0 || warn !== 1'b0) begin errors++; $display("FAIL dis_state: state %0d warn %0b want 0/0", st, warn); end
    for (int i = 0; i < 100; i++) begin
      step();
      if (cpu_rst) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || to_cnt !== 8'd0) begin errors++; $display("FAIL dis_no_bite: seen %0b to %0d want 0/0", seen, to_cnt); end
    checks++; if (dut.w_cnt !== 16'd10) begin errors++; $display("FAIL dis_hold: got %0d want 10", dut.w_cnt); end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    en = 1'b1;
    step();
    repeat (11) step();
    step();
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL mid_pre: got %0b want 1", cpu_rst); end
    rst = 1'b1;
    #1;
    checks++; if (cpu_rst !== 1'b0 || to_cnt !== 8'd0 || st !== 2'd0) begin errors++; $display("FAIL mid_reset: rst %0b to %0d state %0d want 0/0/0", cpu_rst, to_cnt, st); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    pw_en = 1'b1; pdata = 16'd1;
    step();
    pw_en = 1'b0; en = 1'b1;
    step();
    checks++; if (st !== 2'd1 || dut.w_cnt !== 16'd1 || warn !== 1'b1) begin errors++; $display("FAIL sat_start: state %0d cnt %0d warn %0b want 1/1/1", st, dut.w_cnt, warn); end
    repeat (600) step();
    checks++; if (to_cnt !== 8'd100) begin errors++; $display("FAIL sat_100: got %0d want 100", to_cnt); end
    repeat (1300) step();
    checks++; if (to_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", to_cnt); end
  endtask

  initial begin
    test_reset();
    test_bite();
    test_kick_periodic();
    test_kick_at_zero();
    test_zero_write_bite_toggles();
    test_disable();
    test_reset_mid_pulse();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
